svfloat_itof_seq: RTL and testbench
===================================

SVFLOAT_ITOF_SEQ -- requirements
Module: svfloat_itof_seq

Interface
- REQ-001: The module SHALL have parameter `float`, default `svfloat::float32`. It is the floating-point packed struct type with fields sign, exponent and mantissa.
- REQ-002: The module SHALL have parameter `width`, default 32. It is the total number of integer input bits.
- REQ-003: The module SHALL have parameter `frac`, default 0. It is the number of fractional bits in the fixed-point input.
- REQ-004: Port `clk`, input, 1 bit: the single clock. All state SHALL update on its rising edge.
- REQ-005: Port `rst`, input, 1 bit: reset, synchronous and active-high.
- REQ-006: Port `in_valid`, input, 1 bit: the input word is offered.
- REQ-007: Port `in_ready`, output, 1 bit: the block can accept an input.
- REQ-008: Port `in`, input, `width` bits: the fixed-point integer to convert.
- REQ-009: Port `issigned`, input, 1 bit: `in` is two's-complement. It SHALL be sampled together with `in`.
- REQ-010: Port `out_valid`, output, 1 bit: the result is valid.
- REQ-011: Port `out_ready`, input, 1 bit: the consumer accepts the result.
- REQ-012: Port `out`, output, type `float`: the converted floating-point value.

Function
- REQ-013: The block SHALL be a four-state FSM with states IDLE, NORM, ROUND and DONE.
  - `in_ready` = (state == IDLE).
  - `out_valid` = (state == DONE).
- REQ-014: An input handshake SHALL occur when `in_valid` and `in_ready` are both high. It SHALL latch:
  - neg = `issigned` & `in[width-1]`;
  - mag = neg ? -`in` : `in`, as an unsigned `width`-bit value (signed minimum gives 2^(width-1));
  - shift counter cleared to 0.
- REQ-015: After the handshake, the next state SHALL be DONE if mag == 0 (result +0, sign 0), otherwise NORM.
- REQ-016: In NORM:
  - if mag[width-1] == 1, the next state SHALL be ROUND;
  - otherwise mag SHALL shift left by 1, the counter SHALL increment, and the state SHALL stay NORM.
- REQ-017: Let p = width-1-count, the index of the original leading one. The unbiased exponent SHALL be p - frac. Bias SHALL be 2^(E-1)-1, where E is the exponent field width.
- REQ-018: In ROUND, with M = mantissa width:
  - kept = mag[width-2 -: M], zero-padded if fewer bits exist;
  - guard = the next lower bit;
  - sticky = OR of all remaining lower bits.
- REQ-019: Rounding SHALL be round-to-nearest-even: increment kept if guard & (sticky | kept[0]).
- REQ-020: If the rounding increment carries out of the mantissa, the mantissa SHALL become 0 and the exponent SHALL increment by 1.
- REQ-021: Range limits:
  - a biased exponent ≥ 2^E-1 SHALL produce ±infinity (exponent all ones, mantissa 0);
  - a biased exponent ≤ 0 SHALL produce ±0 (no subnormals).
- REQ-022: ROUND SHALL always go to DONE, and the result SHALL be registered into `out`.
- REQ-023: Latency from input handshake to `out_valid` high SHALL be:
  - 1 cycle for zero;
  - otherwise 3 + (width-1-p) cycles.
- REQ-024: In DONE, `out` and `out_valid` SHALL hold stable until `out_ready` is high. The state SHALL then return to IDLE on that edge.
- REQ-025: No new input SHALL be accepted in the DONE cycle (no overlap); throughput is one conversion per busy period plus one IDLE cycle.
- REQ-026: `in`/`issigned` changes while not in IDLE SHALL have no effect on the conversion in progress.

Reset
- REQ-027: While `rst` is high at a clock edge, the state SHALL go to IDLE and `out_valid` SHALL be 0. `out` SHALL be all zeros, and mag, neg and the counter SHALL be cleared.
- REQ-028: Reset in any state, including mid-NORM or while DONE is stalled, SHALL abort the conversion with no output. `in_ready` SHALL be 1 in the first cycle after reset is released.
- REQ-029: A handshake presented in the same cycle as reset SHALL be ignored.

Verification (float32, width 32, frac 0)
- REQ-030: `in`=0x00000001, unsigned, `out_ready`=1 → `out`=0x3F800000 after 34 cycles.
- REQ-031: `in`=0x80000000 signed → 0xCF000000 after 3 cycles. `in`=0xFFFFFFFF signed → 0xBF800000. `in`=0xFFFFFFFF unsigned → 0x4F800000 (rounded up, exponent carry).
- REQ-032: Rounding ties:
  - `in`=0x01000001 → 0x4B800000 (tie to even);
  - `in`=0x01000003 → 0x4B800002.
- REQ-033: `in`=0 → `out`=0x00000000 with latency 1, and `in_ready` low for exactly that busy period.
- REQ-034: Backpressure: `out_ready`=0 for 10 cycles in DONE → `out` stable, `out_valid`=1 and `in_ready`=0 throughout. Then `out_ready`=1 → IDLE on the next edge.
- REQ-035: Assert `rst` during NORM for `in`=1 → `out_valid` never rises. The next input, 0x00000002, yields 0x40000000.

Source files
------------

// File: rtl/svfloat_itof_seq.sv
// Sequential fixed-point integer to float converter.
// Normalises one bit per cycle, then rounds to nearest-even.
package svfloat;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32;
endpackage

module svfloat_itof_seq #(
  parameter type float = svfloat::float32,
  parameter int  width = 32,
  parameter int  frac  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in,
  input  logic             issigned,
  output logic             out_valid,
  input  logic             out_ready,
  output float             out
);

  localparam int M    = $bits(out.mantissa);
  localparam int E    = $bits(out.exponent);
  localparam int XW   = width + M;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int EMAX = (1 << E) - 1;
  localparam int CW   = $clog2(width) + 1;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t           state;
  logic [width-1:0] mag;
  logic             neg;
  logic [CW-1:0]    cnt;

  logic             in_neg;
  logic [width-1:0] in_mag;

  logic [XW-1:0]    ext;
  logic [M-1:0]     kept;
  logic             guard;
  logic             sticky;
  logic             inc;
  logic [M:0]       sum;
  int               ebias;
  float             res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign in_neg = issigned & in[width-1];
  assign in_mag = in_neg ? -in : in;

  // mag is normalised here: its MSB is the hidden one
  always_comb begin
    ext    = {mag[width-2:0], {(M + 1){1'b0}}};
    kept   = ext[XW-1 -: M];
    guard  = ext[XW-1-M];
    sticky = |ext[XW-2-M:0];
    inc    = guard & (sticky | kept[0]);
    sum    = {1'b0, kept} + {{M{1'b0}}, inc};
    ebias  = width - 1 - int'(cnt) - frac
           + BIAS + int'(sum[M]);
    res      = '0;
    res.sign = neg;
    if (ebias >= EMAX) begin
      res.exponent = '1;
    end else if (ebias > 0) begin
      res.exponent = ebias[E-1:0];
      res.mantissa = sum[M-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mag   <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      out   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            neg <= in_neg;
            mag <= in_mag;
            cnt <= '0;
            if (in_mag == '0) begin
              out   <= '0;
              state <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (mag[width-1]) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            cnt <= cnt + CW'(1);
          end
        end
        ROUND: begin
          out   <= res;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svfloat_itof_seq.sv
// Directed and random checks for svfloat_itof_seq (float32, 32-bit int).
// Expected values are queued at issue and popped on out_valid.
module tb_svfloat_itof_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_d;
  logic        issigned;
  logic        out_valid;
  logic        out_ready;
  svfloat::float32 out_f;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] val;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  svfloat_itof_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (in_d),
    .issigned (issigned),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out_f)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference via IEEE double, then RNE down to single
  function automatic exp_t ref_f(logic [31:0] v, logic s);
    exp_t        r;
    logic        ng;
    logic [31:0] m;
    logic [63:0] d;
    int          p;
    logic [23:0] mt;
    int          e;
    ng = s & v[31];
    m  = ng ? -v : v;
    if (m == 0) begin
      r.val = 32'h0;
      r.lat = 1;
      return r;
    end
    d  = $realtobits(real'(longint'({32'd0, m})));
    p  = int'(d[62:52]) - 1023;
    mt = {1'b0, d[51:29]};
    if (d[28] & ((|d[27:0]) | mt[0])) mt = mt + 24'd1;
    e  = p + 127 + int'(mt[23]);
    r.val = {ng, e[7:0], mt[22:0]};
    r.lat = 3 + (31 - p);
    return r;
  endfunction

  task automatic convert(string tag, logic [31:0] v, logic s,
                         logic [31:0] ev, int lat, int stall);
    exp_t x;
    exp_t got;
    int   n;
    logic [31:0] held;
    x.val = ev;
    x.lat = lat;
    sb.push_back(x);
    out_ready = (stall == 0);
    chk({tag, ":ready"}, 64'(in_ready), 64'd1);
    in_d     = v;
    issigned = s;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_d     = $urandom;
    issigned = 1'($urandom);
    n = 1;
    while (!out_valid && n < 200) begin
      step();
      in_d = $urandom;
      n++;
    end
    got = sb.pop_front();
    chk({tag, ":valid"}, 64'(out_valid), 64'd1);
    chk({tag, ":lat"}, 64'(n), 64'(got.lat));
    chk({tag, ":out"}, 64'(out_f), 64'(got.val));
    chk({tag, ":busy"}, 64'(in_ready), 64'd0);
    held = out_f;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      step();
      chk({tag, ":hold"}, 64'(out_f), 64'(held));
      chk({tag, ":hv"}, 64'(out_valid), 64'd1);
      chk({tag, ":hr"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk({tag, ":idle"}, 64'(in_ready), 64'd1);
    chk({tag, ":ov0"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    exp_t        r;
    logic [31:0] v;
    logic        s;
    int          seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_d      = '0;
    issigned  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst:out", 64'(out_f), 64'd0);
    chk("rst:ov", 64'(out_valid), 64'd0);
    rst = 1'b0;
    step();
    chk("rst:ready", 64'(in_ready), 64'd1);

    convert("one", 32'h00000001, 1'b0, 32'h3F800000, 34, 0);
    convert("smin", 32'h80000000, 1'b1, 32'hCF000000, 3, 0);
    convert("m1", 32'hFFFFFFFF, 1'b1, 32'hBF800000, 34, 0);
    convert("umax", 32'hFFFFFFFF, 1'b0, 32'h4F800000, 3, 0);
    convert("tie", 32'h01000001, 1'b0, 32'h4B800000, 10, 0);
    convert("tie3", 32'h01000003, 1'b0, 32'h4B800002, 10, 0);
    convert("zero", 32'h00000000, 1'b1, 32'h00000000, 1, 0);
    convert("bp", 32'h00001234, 1'b0, 32'h4591A000, 22, 10);

    // reset mid-NORM aborts the conversion
    in_d     = 32'h1;
    issigned = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort:ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("abort:noout", 64'(seen), 64'd0);

    // handshake during reset is ignored
    rst      = 1'b1;
    in_d     = 32'h5;
    in_valid = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (!in_ready || out_valid) seen++;
      step();
    end
    chk("rsths:ignored", 64'(seen), 64'd0);

    convert("two", 32'h00000002, 1'b0, 32'h40000000, 33, 0);

    for (int i = 0; i < 8; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      s = 1'($urandom);
      r = ref_f(v, s);
      convert("rnd", v, s, r.val, r.lat, i % 3);
    end

    chk("sb:empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
